// File: rtl/tau_microcode_pkg.sv
// Shared widths, state encoding and address type for the microcode sequencer.
package tau_microcode_pkg;

  localparam int OPCODE_W = 8;
  localparam int STEP_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } useq_state_t;

  typedef logic [OPCODE_W+STEP_W-1:0] ucode_addr_t;

endpackage

// File: rtl/microcode_watchdog.sv
// Per-instruction ACTIVE-cycle counter; flags the enabled edge on which the count reaches WATCHDOG_MAX.
module microcode_watchdog #(
  parameter int WATCHDOG_MAX = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(WATCHDOG_MAX + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != CNT_W'(WATCHDOG_MAX))) begin
      count <= count + CNT_W'(1);
    end
  end

  // High on the enabled edge that would bring the count to WATCHDOG_MAX.
  assign expired = count_en && (count == CNT_W'(WATCHDOG_MAX - 1));

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode ROM address generator: {opcode, step} with micro-branches and a sticky overflow fault.
// Optional cycle watchdog against micro-branch loops is built when MICROCODE_WATCHDOG_EN is defined.
module microcode_sequencer
  import tau_microcode_pkg::*;
#(
  parameter int OPCODE_W     = tau_microcode_pkg::OPCODE_W,
  parameter int STEP_W       = tau_microcode_pkg::STEP_W,
  parameter int WATCHDOG_MAX = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load_n,
  input  logic                       enable,
  input  logic [OPCODE_W-1:0]        opcode,
  input  logic                       finish,
  input  logic                       ubranch_valid,
  input  logic [STEP_W-1:0]          ubranch_target,
  output logic [OPCODE_W+STEP_W-1:0] microcode_address,
  output logic [STEP_W-1:0]          step,
  output logic                       running,
  output logic                       overflow_error
);

  localparam logic [STEP_W-1:0] STEP_LAST = '1;

  useq_state_t         state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                error_q, error_d;
  logic                wd_trip;

`ifdef MICROCODE_WATCHDOG_EN
  microcode_watchdog #(
    .WATCHDOG_MAX (WATCHDOG_MAX)
  ) u_watchdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (!load_n && (state_q != FAULT)),
    .count_en (load_n && enable && (state_q == ACTIVE)),
    .expired  (wd_trip)
  );
`else
  logic [31:0] unused_wd_max;
  assign unused_wd_max = 32'(WATCHDOG_MAX);
  assign wd_trip       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    step_d   = step_q;
    error_d  = error_q;
    if (state_q != FAULT) begin
      if (!load_n) begin
        state_d  = ACTIVE;
        opcode_d = opcode;
        step_d   = '0;
      end else if ((state_q == ACTIVE) && enable) begin
        // finish outranks every other step action, including the watchdog.
        if (finish) begin
          state_d = DONE;
        end else if (wd_trip) begin
          state_d = FAULT;
          error_d = 1'b1;
        end else if (ubranch_valid) begin
          step_d = ubranch_target;
        end else if (step_q == STEP_LAST) begin
          state_d = FAULT;
          error_d = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      step_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      error_q  <= error_d;
    end
  end

  assign microcode_address = {opcode_q, step_q};
  assign step              = step_q;
  assign running           = (state_q == ACTIVE);
  assign overflow_error    = error_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: spec-level reference model checked every cycle plus literal expectations.
module tb_microcode_sequencer;

  localparam int WDMAX = 8;

  logic        clock = 1'b0;
  logic        reset_n, load_n, enable, finish, ubranch_valid;
  logic [7:0]  opcode;
  logic [3:0]  ubranch_target;
  logic [11:0] microcode_address;
  logic [3:0]  step;
  logic        running, overflow_error;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Reference model: 0 idle, 1 active, 2 done, 3 fault.
  int m_st = 0, m_op = 0, m_step = 0, m_err = 0, m_wd = 0;

  microcode_sequencer #(
    .OPCODE_W     (8),
    .STEP_W       (4),
    .WATCHDOG_MAX (WDMAX)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .load_n            (load_n),
    .enable            (enable),
    .opcode            (opcode),
    .finish            (finish),
    .ubranch_valid     (ubranch_valid),
    .ubranch_target    (ubranch_target),
    .microcode_address (microcode_address),
    .step              (step),
    .running           (running),
    .overflow_error    (overflow_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (!reset_n) begin
      m_st = 0; m_op = 0; m_step = 0; m_err = 0; m_wd = 0;
    end else if (m_st == 3) begin
      m_st = 3;
    end else if (!load_n) begin
      m_st = 1; m_op = opcode; m_step = 0; m_wd = 0;
    end else if (m_st == 1 && enable) begin
      m_wd++;
      if (finish) m_st = 2;
`ifdef MICROCODE_WATCHDOG_EN
      else if (m_wd >= WDMAX) begin m_st = 3; m_err = 1; end
`endif
      else if (ubranch_valid) m_step = ubranch_target;
      else if (m_step == 15) begin m_st = 3; m_err = 1; end
      else m_step = m_step + 1;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("model_addr", microcode_address, m_op * 16 + m_step);
      chk("model_step", step, m_step);
      chk("model_running", running, (m_st == 1) ? 1 : 0);
      chk("model_overflow", overflow_error, m_err);
    end
  end

  task automatic cyc(input bit rn, input bit ln, input bit en, input int op,
                     input bit fin, input bit bv, input int tg);
    reset_n = rn; load_n = ln; enable = en; opcode = 8'(op);
    finish = fin; ubranch_valid = bv; ubranch_target = 4'(tg);
    @(negedge clock);
  endtask

  task automatic ld(input int op);
    cyc(1, 0, 0, op, 0, 0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 0; load_n = 1; enable = 0; opcode = 0;
    finish = 0; ubranch_valid = 0; ubranch_target = 0;
    @(negedge clock);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check_en = 1;
    chk("reset_addr", microcode_address, 12'h000);
    chk("reset_running", running, 0);
    chk("reset_overflow", overflow_error, 0);

    // Reset in the middle of an instruction.
    ld(8'h2A);
    run(3);
    chk("mid_addr", microcode_address, 12'h2A3);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("mid_reset_addr", microcode_address, 12'h000);
    chk("mid_reset_step", step, 0);
    chk("mid_reset_running", running, 0);

    // Linear run ending in DONE.
    ld(8'h05);
    chk("lin_addr0", microcode_address, 12'h050);
    chk("lin_running", running, 1);
    run(1);
    chk("lin_addr1", microcode_address, 12'h051);
    run(1);
    chk("lin_addr2", microcode_address, 12'h052);
    cyc(1, 1, 1, 0, 1, 0, 0);
    chk("lin_done_addr", microcode_address, 12'h052);
    chk("lin_done_running", running, 0);
    run(2);
    chk("lin_done_hold", microcode_address, 12'h052);

    // Micro-branch, then finish outranking a branch.
    ld(8'h10);
    run(1);
    cyc(1, 1, 1, 0, 0, 1, 7);
    chk("br_addr", microcode_address, 12'h107);
    cyc(1, 1, 1, 0, 1, 1, 2);
    chk("br_fin_step", step, 7);
    chk("br_fin_running", running, 0);

    // Load wins over simultaneous enable and finish.
    ld(8'h44);
    run(4);
    chk("sim_pre_addr", microcode_address, 12'h444);
    cyc(1, 0, 1, 8'h77, 1, 0, 0);
    chk("sim_addr", microcode_address, 12'h770);
    chk("sim_running", running, 1);
    cyc(1, 1, 0, 0, 1, 1, 9);
    chk("hold_addr", microcode_address, 12'h770);

    // Branch loop back to step 0.
    ld(8'h21);
    for (int i = 0; i < WDMAX - 1; i++) cyc(1, 1, 1, 0, 0, 1, 0);
    chk("loop_pre_err", overflow_error, 0);
    cyc(1, 1, 1, 0, 0, 1, 0);
`ifdef MICROCODE_WATCHDOG_EN
    chk("wd_err", overflow_error, 1);
    chk("wd_running", running, 0);
`else
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 0, 1, 0);
    chk("loop_no_err", overflow_error, 0);
    chk("loop_addr", microcode_address, 12'h210);
`endif
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Step counter overflow and sticky FAULT.
    ld(8'h03);
    run(15);
`ifndef MICROCODE_WATCHDOG_EN
    chk("ovf_last_addr", microcode_address, 12'h03F);
    chk("ovf_last_err", overflow_error, 0);
    run(1);
    chk("ovf_err", overflow_error, 1);
    chk("ovf_running", running, 0);
    chk("ovf_addr", microcode_address, 12'h03F);
    ld(8'h99);
    cyc(1, 1, 1, 0, 1, 0, 0);
    chk("fault_hold_addr", microcode_address, 12'h03F);
    chk("fault_hold_err", overflow_error, 1);
`else
    run(1);
`endif
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("final_reset_err", overflow_error, 0);
    chk("final_reset_addr", microcode_address, 12'h000);

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
